axi4lite_master_bridge: RTL and testbench

- Single-outstanding AXI4-Lite initiator: converts a simple host request port (one read or write at a time) into AXI4-Lite AW/W/B or AR/R transactions.
- Drives the register-bank slaves generated in this codebase, e.g. from a test sequencer, a boot loader or a soft-CPU shim.
- Returns read data and an error flag with a one-cycle acknowledge.

---
 rtl/axi4lite_master_bridge.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi4lite_master_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master_bridge.sv
// axi4lite_master_bridge
// Single-outstanding AXI4-Lite initiator. It turns a one-at-a-time host
// request port into AW/W/B or AR/R transactions and returns a one-cycle ack
// carrying the read data and an error flag.
//
// Optional feature: define AXI_MASTER_TIMEOUT_EN to add a response watchdog
// of TIMEOUT_CYCLES cycles. When it expires the host gets an early ack with
// err=1 and timeout=1. The bus transaction still runs to completion, and its
// late response is discarded.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transaction, host request accepted here
// ST_WR      | awvalid/wvalid outstanding, each dropping on its own ready
// ST_WR_RESP | both write handshakes done, bready high, waiting for bvalid
// ST_RD_ADDR | arvalid outstanding, waiting for arready
// ST_RD_DATA | rready high, waiting for rvalid
module axi4lite_master_bridge #(
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,
    // host side
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    output logic                  o_busy,
    output logic                  o_ack,
    output logic [31:0]           o_rdata,
    output logic                  o_err,
    output logic                  o_timeout,
    // AXI write address / data / response
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic [2:0]            o_awprot,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    output logic [31:0]           o_wdata,
    output logic [3:0]            o_wstrb,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    // AXI read address / data
    output logic                  o_arvalid,
    input  logic                  i_arready,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic [2:0]            o_arprot,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [31:0]           i_rdata,
    input  logic [1:0]            i_rresp
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA
    } state_t;

    state_t r_state, w_state_nxt;

    logic                  r_awvalid, w_awvalid_nxt;
    logic                  r_wvalid,  w_wvalid_nxt;
    logic                  r_bready,  w_bready_nxt;
    logic                  r_arvalid, w_arvalid_nxt;
    logic                  r_rready,  w_rready_nxt;
    logic                  r_ack,     w_ack_nxt;
    logic                  r_err,     w_err_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic [31:0]           r_rdata,   w_rdata_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;

    logic w_accept;
    logic w_resp_hs;
    logic w_aw_left;
    logic w_w_left;
    logic w_tmo_hit;
    logic w_tmo_fired;
    logic w_unused;

    assign w_accept  = (r_state == ST_IDLE) && i_req;
    assign w_resp_hs = ((r_state == ST_WR_RESP) && i_bvalid && r_bready) ||
                       ((r_state == ST_RD_DATA) && i_rvalid && r_rready);
    assign w_aw_left = r_awvalid && !i_awready;
    assign w_w_left  = r_wvalid  && !i_wready;

    // Only resp[1] separates OKAY/EXOKAY from SLVERR/DECERR.
    assign w_unused = ^{1'b0, i_bresp[0], i_rresp[0]};

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_tmo_fired;

    // A response arriving in the same cycle as expiry wins and is acked normally.
    assign w_tmo_hit   = (r_state != ST_IDLE) && !r_tmo_fired && !w_resp_hs &&
                         (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_tmo_fired = r_tmo_fired;

    // Watchdog: restarts on acceptance, counts busy cycles, saturates at the limit
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_tmo_cnt   <= '0;
            r_tmo_fired <= 1'b0;
        end else if (w_accept) begin
            r_tmo_cnt   <= '0;
            r_tmo_fired <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            if (r_tmo_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_hit) begin
                r_tmo_fired <= 1'b1;
            end
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign w_tmo_fired  = 1'b0;
    assign w_unused_tmo = TIMEOUT_CYCLES[0];
`endif

    // Next-state and next registered-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_ack_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_timeout_nxt = 1'b0;
        w_rdata_nxt   = r_rdata;

        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    if (i_we) begin
                        w_state_nxt   = ST_WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            ST_WR: begin
                w_awvalid_nxt = w_aw_left;
                w_wvalid_nxt  = w_w_left;
                if (!w_aw_left && !w_w_left) begin
                    w_state_nxt  = ST_WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (i_bvalid && r_bready) begin
                    w_state_nxt  = ST_IDLE;
                    w_bready_nxt = 1'b0;
                    if (!w_tmo_fired) begin
                        w_ack_nxt = 1'b1;
                        w_err_nxt = i_bresp[1];
                    end
                end
            end
            ST_RD_ADDR: begin
                if (r_arvalid && i_arready) begin
                    w_state_nxt   = ST_RD_DATA;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (i_rvalid && r_rready) begin
                    w_state_nxt  = ST_IDLE;
                    w_rready_nxt = 1'b0;
                    if (!w_tmo_fired) begin
                        w_ack_nxt   = 1'b1;
                        w_err_nxt   = i_rresp[1];
                        w_rdata_nxt = i_rdata;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_tmo_hit) begin
            w_ack_nxt     = 1'b1;
            w_err_nxt     = 1'b1;
            w_timeout_nxt = 1'b1;
        end
    end

    // State, handshake and result registers; payload captured on acceptance
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_timeout <= w_timeout_nxt;
            r_rdata   <= w_rdata_nxt;
            if (w_accept) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
            end
        end
    end

    assign o_busy    = (r_state != ST_IDLE);
    assign o_ack     = r_ack;
    assign o_err     = r_err;
    assign o_timeout = r_timeout;
    assign o_rdata   = r_rdata;

    assign o_awvalid = r_awvalid;
    assign o_awaddr  = r_addr;
    assign o_awprot  = 3'b000;
    assign o_wvalid  = r_wvalid;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_wstrb;
    assign o_bready  = r_bready;

    assign o_arvalid = r_arvalid;
    assign o_araddr  = r_addr;
    assign o_arprot  = 3'b000;
    assign o_rready  = r_rready;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Directed bench for axi4lite_master_bridge with a small configurable AXI4-Lite
// slave. Cycle 0 is the cycle in which the host presents req.
module tb_axi4lite_master_bridge;

    logic        clk;
    logic        areset;
    logic        req, we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        busy, ack, err, timeout;
    logic [31:0] rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [2:0]  awaddr, araddr, awprot, arprot;
    logic [31:0] wdata_o, rdata_i;
    logic [3:0]  wstrb_o;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_mis = 0;
    int ack_cnt = 0;

    // slave configuration
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          ar_delay = 0;
    int          resp_gap = 1;
    logic [1:0]  bresp_val = 2'b00;
    logic [1:0]  rresp_val = 2'b00;
    logic [31:0] rdata_val = 32'h0;

    // slave state
    int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_done, w_done, b_pend, r_pend;

    axi4lite_master_bridge dut (
        .i_aclk(clk), .i_areset(areset),
        .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata), .i_wstrb(wstrb),
        .o_busy(busy), .o_ack(ack), .o_rdata(rdata), .o_err(err), .o_timeout(timeout),
        .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awprot(awprot),
        .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata_o), .o_wstrb(wstrb_o),
        .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
        .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arprot(arprot),
        .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata_i), .i_rresp(rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid  && (w_cnt  >= w_delay);
    assign arready = arvalid && (ar_cnt >= ar_delay);
    assign bvalid  = b_pend && (b_cnt == 0);
    assign rvalid  = r_pend && (r_cnt == 0);
    assign bresp   = bresp_val;
    assign rresp   = rresp_val;
    assign rdata_i = rdata_val;

    always @(posedge clk) begin
        if (areset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1; else if (awvalid) aw_cnt <= 0;
            if (wvalid && !wready)   w_cnt  <= w_cnt + 1;  else if (wvalid)  w_cnt  <= 0;
            if (arvalid && !arready) ar_cnt <= ar_cnt + 1; else if (arvalid) ar_cnt <= 0;
            if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                b_pend  <= 1'b1;
                b_cnt   <= resp_gap;
            end else begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
                if (b_pend && b_cnt != 0) b_cnt <= b_cnt - 1;
                if (bvalid && bready) b_pend <= 1'b0;
            end
            if (arvalid && arready) begin
                r_pend <= 1'b1;
                r_cnt  <= resp_gap;
            end else begin
                if (r_pend && r_cnt != 0) r_cnt <= r_cnt - 1;
                if (rvalid && rready) r_pend <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (ack === 1'b1) ack_cnt++;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, output int n);
        n = 0;
        while (ack !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
    endtask

    task automatic host_req(input logic w, input logic [2:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    endtask

    int n;

    initial begin
        areset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        tick(); tick();
        chk("rst_busy",    {31'b0, busy},    0);
        chk("rst_ack",     {31'b0, ack},     0);
        chk("rst_err",     {31'b0, err},     0);
        chk("rst_tmo",     {31'b0, timeout}, 0);
        chk("rst_awvalid", {31'b0, awvalid}, 0);
        chk("rst_wvalid",  {31'b0, wvalid},  0);
        chk("rst_arvalid", {31'b0, arvalid}, 0);
        chk("rst_bready",  {31'b0, bready},  0);
        chk("rst_rready",  {31'b0, rready},  0);
        chk("rst_rdata",   rdata,            0);
        areset = 1'b0;
        tick();

        // zero-wait write, exact cycle timing
        host_req(1'b1, 3'd4, 32'hDEADBEEF, 4'hF);
        chk("w1_c0_busy", {31'b0, busy}, 0);
        tick(); req = 1'b0;
        chk("w1_c1_awvalid", {31'b0, awvalid}, 1);
        chk("w1_c1_wvalid",  {31'b0, wvalid},  1);
        chk("w1_c1_awaddr",  {29'b0, awaddr},  4);
        chk("w1_c1_wdata",   wdata_o,          32'hDEADBEEF);
        chk("w1_c1_wstrb",   {28'b0, wstrb_o}, 32'hF);
        chk("w1_c1_awprot",  {29'b0, awprot},  0);
        chk("w1_c1_busy",    {31'b0, busy},    1);
        tick();
        chk("w1_c2_bready",  {31'b0, bready},  1);
        chk("w1_c2_awvalid", {31'b0, awvalid}, 0);
        chk("w1_c2_busy",    {31'b0, busy},    1);
        tick();
        chk("w1_c3_busy", {31'b0, busy}, 1);
        chk("w1_c3_ack",  {31'b0, ack},  0);
        tick();
        chk("w1_c4_ack",    {31'b0, ack},     1);
        chk("w1_c4_err",    {31'b0, err},     0);
        chk("w1_c4_tmo",    {31'b0, timeout}, 0);
        chk("w1_c4_busy",   {31'b0, busy},    0);
        chk("w1_c4_bready", {31'b0, bready},  0);
        tick();

        // awready held low 3 cycles, wready immediate, wstrb=0 still issued
        aw_delay = 3;
        host_req(1'b1, 3'd6, 32'h11223344, 4'h0);
        tick(); req = 1'b0;
        chk("w2_c1_awvalid", {31'b0, awvalid}, 1);
        chk("w2_c1_wvalid",  {31'b0, wvalid},  1);
        chk("w2_c1_wstrb",   {28'b0, wstrb_o}, 0);
        tick();
        chk("w2_c2_awvalid", {31'b0, awvalid}, 1);
        chk("w2_c2_wvalid",  {31'b0, wvalid},  0);
        chk("w2_c2_awaddr",  {29'b0, awaddr},  6);
        tick();
        chk("w2_c3_awvalid", {31'b0, awvalid}, 1);
        tick();
        chk("w2_c4_awvalid", {31'b0, awvalid}, 1);
        chk("w2_c4_awaddr",  {29'b0, awaddr},  6);
        chk("w2_c4_bready",  {31'b0, bready},  0);
        tick();
        chk("w2_c5_awvalid", {31'b0, awvalid}, 0);
        chk("w2_c5_bready",  {31'b0, bready},  1);
        wait_ack("w2", n);
        chk("w2_ack_wait", n, 2);
        chk("w2_err", {31'b0, err}, 0);
        tick();
        chk("w2_ack_pulse", {31'b0, ack}, 0);
        chk("w2_ack_count", ack_cnt, 2);
        aw_delay = 0;

        // read, then a write issued in the read's ack cycle
        rdata_val = 32'h12345678; rresp_val = 2'b00;
        host_req(1'b0, 3'd0, 32'h0, 4'h0);
        tick(); req = 1'b0;
        chk("r3_c1_arvalid", {31'b0, arvalid}, 1);
        chk("r3_c1_araddr",  {29'b0, araddr},  0);
        chk("r3_c1_arprot",  {29'b0, arprot},  0);
        tick();
        chk("r3_c2_arvalid", {31'b0, arvalid}, 0);
        chk("r3_c2_rready",  {31'b0, rready},  1);
        tick();
        chk("r3_c3_ack", {31'b0, ack}, 0);
        tick();
        chk("r3_c4_ack",   {31'b0, ack}, 1);
        chk("r3_c4_rdata", rdata,        32'h12345678);
        chk("r3_c4_err",   {31'b0, err}, 0);
        host_req(1'b1, 3'd1, 32'hA5A5A5A5, 4'h3);
        tick(); req = 1'b0;
        chk("w3_c1_awvalid", {31'b0, awvalid}, 1);
        chk("w3_c1_awaddr",  {29'b0, awaddr},  1);
        wait_ack("w3", n);
        chk("w3_ack_wait", n, 3);
        chk("w3_rdata_held", rdata, 32'h12345678);
        chk("w3_err", {31'b0, err}, 0);
        tick();
        chk("idle_rdata_held", rdata, 32'h12345678);

        // SLVERR read, req during busy dropped, DECERR write
        rdata_val = 32'h0BADF00D; rresp_val = 2'b10;
        host_req(1'b0, 3'd5, 32'h0, 4'h0);
        tick();
        host_req(1'b1, 3'd7, 32'hFFFFFFFF, 4'hF);
        tick(); req = 1'b0;
        wait_ack("r4", n);
        chk("r4_ack_wait", n, 2);
        chk("r4_err",   {31'b0, err}, 1);
        chk("r4_rdata", rdata,        32'h0BADF00D);
        tick();
        chk("r4_no_queue_busy",    {31'b0, busy},    0);
        chk("r4_no_queue_awvalid", {31'b0, awvalid}, 0);
        bresp_val = 2'b11;
        host_req(1'b1, 3'd2, 32'h00000042, 4'h1);
        tick(); req = 1'b0;
        wait_ack("w4", n);
        chk("w4_ack_wait", n, 3);
        chk("w4_err", {31'b0, err}, 1);
        tick();
        chk("w4_err_cleared", {31'b0, err}, 0);
        tick();
        chk("w4_ack_count", ack_cnt, 6);
        bresp_val = 2'b00; rresp_val = 2'b00;

        // reset in WR_RESP, then a normal read
        host_req(1'b1, 3'd3, 32'h55555555, 4'hF);
        tick(); req = 1'b0;
        tick();
        chk("w5_c2_bready", {31'b0, bready}, 1);
        areset = 1'b1;
        tick();
        chk("w5_rst_bready", {31'b0, bready}, 0);
        chk("w5_rst_busy",   {31'b0, busy},   0);
        chk("w5_rst_ack",    {31'b0, ack},    0);
        areset = 1'b0;
        tick(); tick(); tick();
        chk("w5_no_ack_count", ack_cnt, 6);
        rdata_val = 32'hCAFEF00D;
        host_req(1'b0, 3'd3, 32'h0, 4'h0);
        tick(); req = 1'b0;
        chk("r5_c1_araddr", {29'b0, araddr}, 3);
        wait_ack("r5", n);
        chk("r5_ack_wait", n, 3);
        chk("r5_rdata", rdata, 32'hCAFEF00D);
        chk("r5_err", {31'b0, err}, 0);
        chk("r5_tmo", {31'b0, timeout}, 0);
        tick();
        chk("r5_ack_count", ack_cnt, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
